axi4s_uart_rx: RTL and testbench
================================

// Module: axi4s_uart_rx
// PURPOSE
//  UART receiver (8N1, LSB first); emits each received byte as a single AXI4-Stream beat.
//  Receive-side counterpart of the team's AXI4-Stream UART transmitter.
//  Sits between the uart_rxd pad and the byte-stream fabric.
// PARAMETERS
//  ACLK_FREQUENCY  real  200000000  aclk frequency, Hz
//  BAUD_RATE       int   9600       line rate for synthesis
//  BAUD_RATE_SIM   int   50000000   line rate under simulation (synthesis translate_off)
//  SYNC_STAGES     int   2          uart_rxd synchronizer depth, >=2
//  TICS_PER_BEAT   = round(ACLK_FREQUENCY / used baud rate); must be >=4
// PORTS
//  aclk            in   1  clock
//  areset          in   1  synchronous, active-high reset
//  uart_rxd        in   1  asynchronous serial input, idle high
//  rx_byte_tvalid  out  1  byte available
//  rx_byte_tready  in   1  downstream accepts
//  rx_byte_tdata   out  8  received byte
//  rx_byte_tkeep   out  1  constant 1 whenever tvalid=1
//  frame_error     out  1  1-cycle pulse: stop bit sampled low
//  overrun         out  1  1-cycle pulse: byte completed while output register still full
// BEHAVIOUR
//  - Reset (areset=1 at posedge): tvalid=0, tdata=0, tkeep=1, frame_error=0, overrun=0,
//    state=IDLE, synchronizer flops=1. Reset mid-frame aborts the frame; partial data is discarded.
//  - rxd_s = uart_rxd after SYNC_STAGES flops. All decisions use rxd_s only.
//  - States:
//    IDLE: rxd_s 1->0 edge -> START; tic_cnt = TICS_PER_BEAT/2-1.
//    START: count down; at 0, sample. Sample=1 -> IDLE (false start). Sample=0 -> DATA;
//      tic_cnt = TICS_PER_BEAT-1; bit_cnt = 7.
//    DATA: at tic_cnt=0, shift sample into shreg[7] (shift right, LSB first) and reload tic_cnt.
//      After bit_cnt=0 -> STOP.
//    STOP: at tic_cnt=0, sample. Sample=1 -> byte complete, then IDLE.
//      Sample=0 -> frame_error pulse, byte dropped, then WAIT_IDLE.
//    WAIT_IDLE: stay until rxd_s=1, then IDLE. No edge is detected during a break.
//  - Byte complete: the next cycle has tvalid=1 and tdata=shreg.
//    If tvalid=1 and tready=0 in the completion cycle, the new byte is dropped, the held byte
//    is kept, and overrun pulses.
//    Completion in the same cycle as a tvalid&tready handshake: the new byte loads; no overrun.
//  - tvalid and tdata stay stable until tvalid&tready; tvalid then drops, unless the same-cycle
//    load above applies.
//  - Latency: falling edge at the pin -> tvalid is about SYNC_STAGES + TICS_PER_BEAT/2 +
//    9*TICS_PER_BEAT + 1 cycles.
//  - Counter widths: tic_cnt is $clog2(TICS_PER_BEAT) bits; bit_cnt is 3 bits. No wrap beyond reload.
// CONFIGURATION
//  AXI4S_UART_RX_MAJORITY_EN
//  - Defined: each sample (start, data, stop) is the 2-of-3 majority of rxd_s at tic_cnt=1, 0,
//    and the cycle after 0. The decision is taken one cycle later; the state timeline is otherwise
//    unchanged.
//  - Undefined: each sample is the single rxd_s value at tic_cnt=0.
// STRUCTURE
//  - Package axi4s_uart_pkg:
//    - rx state enum {IDLE, START, DATA, STOP, WAIT_IDLE}
//    - function tics_per_beat(real freq, int baud)
//    - used-baud-rate selection (synthesis/simulation), shared with the transmitter
//  - Sub-module uart_rx_sync: SYNC_STAGES-flop synchronizer plus falling-edge detect. Reset value 1.
// TESTING  (ACLK_FREQUENCY=200e6, BAUD_RATE_SIM=10e6 -> TICS_PER_BEAT=20)
//  1. Frame 0xA5, tready=1 -> one beat: tdata=0xA5, tkeep=1; no frame_error, no overrun.
//  2. Low glitch of 5 cycles on idle line -> START rejects it; no beat; back in IDLE.
//  3. Frame 0x3C with stop bit low, then line high, then frame 0x55
//     -> one frame_error pulse; only 0x55 is output.
//  4. tready=0; frames 0x11, 0x22 -> tvalid held with 0x11; overrun pulses at the 0x22 stop;
//     raising tready yields 0x11 only.
//  5. areset=1 for 1 cycle during bit 3 of 0x99 -> tvalid=0, no beat;
//     next frame 0x7E is received intact.
//  6. Frame 0x01 with rxd inverted only on the bit-0 centre sample cycle:
//     macro defined -> 0x01; undefined -> 0x00.

Source files
------------

// File: rtl/axi4s_uart_pkg.sv
// Shared definitions for the AXI4-Stream UART blocks: receiver states, bit-timing helpers
// and the synthesis/simulation baud-rate selection.
package axi4s_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Synthesis tools define SYNTHESIS; anything else runs at the fast simulation line rate.
`ifdef SYNTHESIS
    localparam bit USE_SIM_BAUD = 1'b0;
`else
    localparam bit USE_SIM_BAUD = 1'b1;
`endif

    function automatic int used_baud_rate(int baud, int baud_sim);
        return USE_SIM_BAUD ? baud_sim : baud;
    endfunction

    function automatic int tics_per_beat(real freq, int baud);
        return $rtoi(freq / real'(baud) + 0.5);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous uart_rxd pin into the aclk domain and flags its falling edges.
// All flops reset to the idle-high line level so a reset never fabricates a start edge.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic aclk,
    input  logic areset,
    input  logic uart_rxd,
    output logic rxd_s,
    output logic rxd_fall
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   rxd_prev;

    always_ff @(posedge aclk) begin
        if (areset) begin
            sync_ff  <= '1;
            rxd_prev <= 1'b1;
        end else begin
            sync_ff  <= {sync_ff[SYNC_STAGES-2:0], uart_rxd};
            rxd_prev <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign rxd_s    = sync_ff[SYNC_STAGES-1];
    assign rxd_fall = rxd_prev & ~rxd_s;

endmodule

// File: rtl/axi4s_uart_rx.sv
// 8N1 UART receiver that presents each received byte as one AXI4-Stream beat.
// Define AXI4S_UART_RX_MAJORITY_EN to take every bit as a 2-of-3 vote around its centre.
module axi4s_uart_rx
    import axi4s_uart_pkg::*;
#(
    parameter real ACLK_FREQUENCY = 200000000.0,
    parameter int  BAUD_RATE      = 9600,
    parameter int  BAUD_RATE_SIM  = 50000000,
    parameter int  SYNC_STAGES    = 2
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       uart_rxd,
    output logic       rx_byte_tvalid,
    input  logic       rx_byte_tready,
    output logic [7:0] rx_byte_tdata,
    output logic       rx_byte_tkeep,
    output logic       frame_error,
    output logic       overrun
);

    localparam int TICS = tics_per_beat(ACLK_FREQUENCY, used_baud_rate(BAUD_RATE, BAUD_RATE_SIM));
    localparam int TW   = $clog2(TICS);
    localparam logic [TW-1:0] START_RELOAD = TW'(TICS / 2 - 1);

    logic            rxd_s;
    logic            rxd_fall;
    rx_state_t       state, state_next;
    logic [TW-1:0]   tic_cnt, tic_next;
    logic [2:0]      bit_cnt, bit_next;
    logic [7:0]      shreg, shreg_next;
    logic            active;
    logic            decide;
    logic            sample;
    logic            byte_done;
    logic            stop_err;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .aclk     (aclk),
        .areset   (areset),
        .uart_rxd (uart_rxd),
        .rxd_s    (rxd_s),
        .rxd_fall (rxd_fall)
    );

    assign active = (state == START) || (state == DATA) || (state == STOP);

`ifdef AXI4S_UART_RX_MAJORITY_EN
    // The vote needs the sample after the centre, so the decision lands one cycle late; the
    // shorter reload keeps later bit centres exactly TICS apart.
    localparam logic [TW-1:0] BIT_RELOAD = TW'(TICS - 2);

    logic [1:0] rxd_hist;
    logic       sample_due;

    always_ff @(posedge aclk) begin
        if (areset) begin
            rxd_hist   <= 2'b11;
            sample_due <= 1'b0;
        end else begin
            rxd_hist   <= {rxd_hist[0], rxd_s};
            sample_due <= active && (tic_cnt == '0) && !sample_due;
        end
    end

    assign decide = sample_due;
    assign sample = (rxd_hist[1] & rxd_hist[0]) | (rxd_hist[1] & rxd_s) | (rxd_hist[0] & rxd_s);
`else
    localparam logic [TW-1:0] BIT_RELOAD = TW'(TICS - 1);

    assign decide = active && (tic_cnt == '0);
    assign sample = rxd_s;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= IDLE;
            tic_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            tic_cnt <= tic_next;
            bit_cnt <= bit_next;
            shreg   <= shreg_next;
        end
    end

    always_comb begin
        state_next = state;
        tic_next   = tic_cnt;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        byte_done  = 1'b0;
        stop_err   = 1'b0;

        if (active && !decide && (tic_cnt != '0)) begin
            tic_next = tic_cnt - TW'(1);
        end

        case (state)
            IDLE: begin
                if (rxd_fall) begin
                    state_next = START;
                    tic_next   = START_RELOAD;
                end
            end
            START: begin
                if (decide) begin
                    if (sample) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        tic_next   = BIT_RELOAD;
                        bit_next   = 3'd7;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shreg_next = {sample, shreg[7:1]};
                    tic_next   = BIT_RELOAD;
                    if (bit_cnt == 3'd0) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_cnt - 3'd1;
                    end
                end
            end
            STOP: begin
                if (decide) begin
                    if (sample) begin
                        byte_done  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_err   = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rxd_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A completing byte may only load when the holding register is free or draining this cycle.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rx_byte_tvalid <= 1'b0;
            rx_byte_tdata  <= '0;
            frame_error    <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            frame_error <= stop_err;
            overrun     <= byte_done && rx_byte_tvalid && !rx_byte_tready;
            if (byte_done && (!rx_byte_tvalid || rx_byte_tready)) begin
                rx_byte_tvalid <= 1'b1;
                rx_byte_tdata  <= shreg;
            end else if (rx_byte_tvalid && rx_byte_tready) begin
                rx_byte_tvalid <= 1'b0;
            end
        end
    end

    assign rx_byte_tkeep = 1'b1;

endmodule

// File: tb/tb_axi4s_uart_rx.sv
// Self-checking bench for axi4s_uart_rx at 20 aclk cycles per bit; follows the
// AXI4S_UART_RX_MAJORITY_EN setting of the build when predicting sampled bits.
`timescale 1ns/1ps
module tb_axi4s_uart_rx;

    localparam int T = 20;

    logic       aclk;
    logic       areset;
    logic       uart_rxd;
    logic       rx_byte_tvalid;
    logic       rx_byte_tready;
    logic [7:0] rx_byte_tdata;
    logic       rx_byte_tkeep;
    logic       frame_error;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] rx_q[$];
    int         fe_cnt   = 0;
    int         ov_cnt   = 0;
    int         keep_bad = 0;

    axi4s_uart_rx #(
        .ACLK_FREQUENCY (200000000.0),
        .BAUD_RATE      (9600),
        .BAUD_RATE_SIM  (10000000),
        .SYNC_STAGES    (2)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .uart_rxd       (uart_rxd),
        .rx_byte_tvalid (rx_byte_tvalid),
        .rx_byte_tready (rx_byte_tready),
        .rx_byte_tdata  (rx_byte_tdata),
        .rx_byte_tkeep  (rx_byte_tkeep),
        .frame_error    (frame_error),
        .overrun        (overrun)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Observes the stream away from the clock edge: accepted beats, pulses and tkeep.
    initial begin
        forever begin
            @(negedge aclk);
            if (rx_byte_tvalid === 1'b1 && rx_byte_tready === 1'b1) rx_q.push_back(rx_byte_tdata);
            if (rx_byte_tvalid === 1'b1 && rx_byte_tkeep !== 1'b1) keep_bad++;
            if (frame_error === 1'b1) fe_cnt++;
            if (overrun === 1'b1) ov_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic clear_obs();
        rx_q.delete();
        fe_cnt   = 0;
        ov_cnt   = 0;
        keep_bad = 0;
    endtask

    function automatic logic [7:0] first_rx();
        return (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    endfunction

    // Line level during cycle c of a frame: start, 8 data bits LSB first, stop; one cycle optionally inverted.
    function automatic logic line_level(input logic [7:0] d, input logic stop_bit, input int inv, input int c);
        int  b;
        logic v;
        b = c / T;
        if (b == 0) v = 1'b0;
        else if (b == 9) v = stop_bit;
        else v = d[b-1];
        if (c == inv) v = ~v;
        return v;
    endfunction

    // Byte a receiver sampling each bit at its centre would recover from the frame waveform.
    function automatic logic [7:0] model_byte(input logic [7:0] d, input int inv);
        logic [7:0] r;
        int         ctr;
        logic       a, b, c;
        for (int k = 0; k < 8; k++) begin
            ctr = T * (k + 1) + T / 2;
            a = line_level(d, 1'b1, inv, ctr - 1);
            b = line_level(d, 1'b1, inv, ctr);
            c = line_level(d, 1'b1, inv, ctr + 1);
`ifdef AXI4S_UART_RX_MAJORITY_EN
            r[k] = (a & b) | (a & c) | (b & c);
`else
            r[k] = b;
`endif
        end
        return r;
    endfunction

    task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input int inv, input int abort_cycle);
        for (int c = 0; c < 10 * T; c++) begin
            if (c == abort_cycle) begin
                areset   = 1'b1;
                uart_rxd = 1'b1;
                tick(1);
                areset   = 1'b0;
                return;
            end
            uart_rxd = line_level(d, stop_bit, inv, c);
            tick(1);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic test_reset();
        areset         = 1'b1;
        uart_rxd       = 1'b1;
        rx_byte_tready = 1'b1;
        tick(4);
        n_checks++;
        if (rx_byte_tvalid !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_tvalid: got %b expected 0", rx_byte_tvalid); end
        n_checks++;
        if (rx_byte_tdata !== 8'h00) begin n_errors++; $display("[TB] FAIL reset_tdata: got %h expected 00", rx_byte_tdata); end
        n_checks++;
        if (rx_byte_tkeep !== 1'b1) begin n_errors++; $display("[TB] FAIL reset_tkeep: got %b expected 1", rx_byte_tkeep); end
        n_checks++;
        if (frame_error !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_frame_error: got %b expected 0", frame_error); end
        n_checks++;
        if (overrun !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
        areset = 1'b0;
        tick(5);
    endtask

    task automatic test_single_frame();
        clear_obs();
        drive_frame(8'hA5, 1'b1, -1, -1);
        tick(10);
        n_checks++;
        if (rx_q.size() != 1) begin n_errors++; $display("[TB] FAIL single_count: got %0d expected 1", rx_q.size()); end
        n_checks++;
        if (first_rx() !== 8'hA5) begin n_errors++; $display("[TB] FAIL single_data: got %h expected a5", first_rx()); end
        n_checks++;
        if (keep_bad != 0) begin n_errors++; $display("[TB] FAIL single_tkeep: got %0d bad cycles expected 0", keep_bad); end
        n_checks++;
        if (fe_cnt != 0) begin n_errors++; $display("[TB] FAIL single_frame_error: got %0d expected 0", fe_cnt); end
        n_checks++;
        if (ov_cnt != 0) begin n_errors++; $display("[TB] FAIL single_overrun: got %0d expected 0", ov_cnt); end
    endtask

    task automatic test_glitch();
        clear_obs();
        uart_rxd = 1'b0;
        tick(5);
        uart_rxd = 1'b1;
        tick(4 * T);
        n_checks++;
        if (rx_q.size() != 0) begin n_errors++; $display("[TB] FAIL glitch_beats: got %0d expected 0", rx_q.size()); end
        n_checks++;
        if (rx_byte_tvalid !== 1'b0) begin n_errors++; $display("[TB] FAIL glitch_tvalid: got %b expected 0", rx_byte_tvalid); end
        n_checks++;
        if (fe_cnt != 0) begin n_errors++; $display("[TB] FAIL glitch_frame_error: got %0d expected 0", fe_cnt); end
        drive_frame(8'h5A, 1'b1, -1, -1);
        tick(10);
        n_checks++;
        if (rx_q.size() != 1) begin n_errors++; $display("[TB] FAIL glitch_recover_count: got %0d expected 1", rx_q.size()); end
        n_checks++;
        if (first_rx() !== 8'h5A) begin n_errors++; $display("[TB] FAIL glitch_recover_data: got %h expected 5a", first_rx()); end
    endtask

    task automatic test_frame_error();
        clear_obs();
        drive_frame(8'h3C, 1'b0, -1, -1);
        tick(T);
        drive_frame(8'h55, 1'b1, -1, -1);
        tick(10);
        n_checks++;
        if (fe_cnt != 1) begin n_errors++; $display("[TB] FAIL ferr_pulses: got %0d expected 1", fe_cnt); end
        n_checks++;
        if (rx_q.size() != 1) begin n_errors++; $display("[TB] FAIL ferr_count: got %0d expected 1", rx_q.size()); end
        n_checks++;
        if (first_rx() !== 8'h55) begin n_errors++; $display("[TB] FAIL ferr_data: got %h expected 55", first_rx()); end
        n_checks++;
        if (ov_cnt != 0) begin n_errors++; $display("[TB] FAIL ferr_overrun: got %0d expected 0", ov_cnt); end
    endtask

    task automatic test_overrun();
        clear_obs();
        rx_byte_tready = 1'b0;
        drive_frame(8'h11, 1'b1, -1, -1);
        tick(5);
        n_checks++;
        if (rx_byte_tvalid !== 1'b1 || rx_byte_tdata !== 8'h11) begin
            n_errors++; $display("[TB] FAIL ovr_first_hold: got valid=%b data=%h expected valid=1 data=11", rx_byte_tvalid, rx_byte_tdata);
        end
        drive_frame(8'h22, 1'b1, -1, -1);
        tick(10);
        n_checks++;
        if (ov_cnt != 1) begin n_errors++; $display("[TB] FAIL ovr_pulses: got %0d expected 1", ov_cnt); end
        n_checks++;
        if (rx_byte_tvalid !== 1'b1 || rx_byte_tdata !== 8'h11) begin
            n_errors++; $display("[TB] FAIL ovr_still_held: got valid=%b data=%h expected valid=1 data=11", rx_byte_tvalid, rx_byte_tdata);
        end
        rx_byte_tready = 1'b1;
        tick(5);
        n_checks++;
        if (rx_q.size() != 1) begin n_errors++; $display("[TB] FAIL ovr_count: got %0d expected 1", rx_q.size()); end
        n_checks++;
        if (first_rx() !== 8'h11) begin n_errors++; $display("[TB] FAIL ovr_data: got %h expected 11", first_rx()); end
        n_checks++;
        if (rx_byte_tvalid !== 1'b0) begin n_errors++; $display("[TB] FAIL ovr_drained: got %b expected 0", rx_byte_tvalid); end
    endtask

    task automatic test_reset_mid_frame();
        clear_obs();
        drive_frame(8'h99, 1'b1, -1, 4 * T + T / 2);
        tick(15 * T);
        n_checks++;
        if (rx_byte_tvalid !== 1'b0) begin n_errors++; $display("[TB] FAIL midrst_tvalid: got %b expected 0", rx_byte_tvalid); end
        n_checks++;
        if (rx_q.size() != 0) begin n_errors++; $display("[TB] FAIL midrst_beats: got %0d expected 0", rx_q.size()); end
        n_checks++;
        if (fe_cnt != 0) begin n_errors++; $display("[TB] FAIL midrst_frame_error: got %0d expected 0", fe_cnt); end
        drive_frame(8'h7E, 1'b1, -1, -1);
        tick(10);
        n_checks++;
        if (rx_q.size() != 1) begin n_errors++; $display("[TB] FAIL midrst_next_count: got %0d expected 1", rx_q.size()); end
        n_checks++;
        if (first_rx() !== 8'h7E) begin n_errors++; $display("[TB] FAIL midrst_next_data: got %h expected 7e", first_rx()); end
    endtask

    task automatic test_centre_glitch();
        logic [7:0] expected;
        clear_obs();
        expected = model_byte(8'h01, T + T / 2);
        drive_frame(8'h01, 1'b1, T + T / 2, -1);
        tick(10);
        n_checks++;
        if (rx_q.size() != 1) begin n_errors++; $display("[TB] FAIL centre_count: got %0d expected 1", rx_q.size()); end
        n_checks++;
        if (first_rx() !== expected) begin n_errors++; $display("[TB] FAIL centre_data: got %h expected %h", first_rx(), expected); end
    endtask

    task automatic test_random_stream();
        logic [7:0] exp_q[$];
        int         exp_fe;
        logic       done;
        logic [7:0] d;
        logic       good;
        clear_obs();
        exp_fe = 0;
        done   = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    d    = 8'($urandom);
                    good = ($urandom_range(0, 4) != 0);
                    drive_frame(d, good, -1, -1);
                    if (good) exp_q.push_back(model_byte(d, -1));
                    else exp_fe++;
                    tick($urandom_range(3, 40));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rx_byte_tready = ($urandom_range(0, 3) != 0);
                    tick(1);
                end
                rx_byte_tready = 1'b1;
            end
        join
        tick(3 * T);
        n_checks++;
        if (rx_q.size() != exp_q.size()) begin n_errors++; $display("[TB] FAIL rand_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        n_checks++;
        if (fe_cnt != exp_fe) begin n_errors++; $display("[TB] FAIL rand_frame_error: got %0d expected %0d", fe_cnt, exp_fe); end
        n_checks++;
        if (ov_cnt != 0) begin n_errors++; $display("[TB] FAIL rand_overrun: got %0d expected 0", ov_cnt); end
        n_checks++;
        if (keep_bad != 0) begin n_errors++; $display("[TB] FAIL rand_tkeep: got %0d bad cycles expected 0", keep_bad); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("[TB] FAIL rand_data[%0d]: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    initial begin
        areset         = 1'b1;
        uart_rxd       = 1'b1;
        rx_byte_tready = 1'b1;
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        test_centre_glitch();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
